// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one RAM port between instruction fetch and load/store
// Data wins ties unless fetch has waited STARVE_MAX grants; stalled accesses abort after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_done,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic        d_gnt,
  output logic        d_done,
  output logic [31:0] d_rdata,
  input  logic        ram_ready,
  input  logic [31:0] ram_data_into_mcu,
  output logic        cs,
  output logic        we,
  output logic        oe,
  output logic [31:0] address,
  output logic [31:0] ram_data_in,
  output logic [1:0]  data_size,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DREAD, DWRITE} state_t;

  state_t      r_state;
  logic [7:0]  r_starve;
  logic [7:0]  r_wait;
  logic        r_if_gnt, r_if_done, r_d_gnt, r_d_done, r_tmo;
  logic        r_cs, r_we, r_oe;
  logic [31:0] r_address, r_wdata, r_if_rdata, r_d_rdata;
  logic [1:0]  r_size;

  logic w_grant_d;
  logic w_starved;
  logic w_unused;

  assign w_starved = if_req && (r_starve == 8'(STARVE_MAX));
  assign w_grant_d = d_req && !w_starved;
  assign w_unused  = ^if_addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_starve   <= 8'd0;
      r_wait     <= 8'd0;
      r_if_gnt   <= 1'b0;
      r_if_done  <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_d_done   <= 1'b0;
      r_tmo      <= 1'b0;
      r_cs       <= 1'b0;
      r_we       <= 1'b0;
      r_oe       <= 1'b0;
      r_address  <= 32'd0;
      r_wdata    <= 32'd0;
      r_size     <= 2'b00;
      r_if_rdata <= 32'd0;
      r_d_rdata  <= 32'd0;
    end else begin
      r_if_gnt  <= 1'b0;
      r_d_gnt   <= 1'b0;
      r_if_done <= 1'b0;
      r_d_done  <= 1'b0;
      r_tmo     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_state   <= d_we ? DWRITE : DREAD;
            r_d_gnt   <= 1'b1;
            r_address <= d_addr;
            r_wdata   <= d_wdata;
            r_size    <= (d_size == 2'b11) ? 2'b10 : d_size;
            r_cs      <= 1'b1;
            r_we      <= d_we;
            r_oe      <= !d_we;
            r_wait    <= 8'd0;
            if (if_req && r_starve < 8'(STARVE_MAX))
              r_starve <= r_starve + 8'd1;
          end else if (if_req) begin
            r_state   <= FETCH;
            r_if_gnt  <= 1'b1;
            r_address <= {if_addr[31:2], 2'b00};
            r_size    <= 2'b10;
            r_cs      <= 1'b1;
            r_we      <= 1'b0;
            r_oe      <= 1'b1;
            r_wait    <= 8'd0;
            r_starve  <= 8'd0;
          end
        end
        default: begin
          if (ram_ready || r_wait == 8'(TIMEOUT - 1)) begin
            r_state <= IDLE;
            r_cs    <= 1'b0;
            r_we    <= 1'b0;
            r_oe    <= 1'b0;
            r_tmo   <= !ram_ready;
            if (r_state == FETCH) begin
              r_if_done <= 1'b1;
              if (ram_ready)
                r_if_rdata <= ram_data_into_mcu;
            end else begin
              r_d_done <= 1'b1;
              if (ram_ready && r_state == DREAD)
                r_d_rdata <= ram_data_into_mcu;
            end
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
      endcase
    end
  end

  assign if_gnt      = r_if_gnt;
  assign if_done     = r_if_done;
  assign if_rdata    = r_if_rdata;
  assign d_gnt       = r_d_gnt;
  assign d_done      = r_d_done;
  assign d_rdata     = r_d_rdata;
  assign cs          = r_cs;
  assign we          = r_we;
  assign oe          = r_oe;
  assign address     = r_address;
  assign ram_data_in = r_wdata;
  assign data_size   = r_size;
  assign timeout_err = r_tmo;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for ram_ready before an access is aborted (range 1-255).
REQ-002 SHALL have parameter STARVE_MAX, default 4: maximum consecutive data grants while a fetch request waits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports if_req (input, 1), if_addr (input, 32), if_gnt (output, 1), if_done (output, 1) and if_rdata (output, 32): the instruction-fetch requester.
REQ-006 SHALL have ports d_req (input, 1), d_we (input, 1), d_addr (input, 32), d_wdata (input, 32), d_size (input, 2), d_gnt (output, 1), d_done (output, 1) and d_rdata (output, 32): the load/store requester.
REQ-007 SHALL have ports ram_ready (input, 1) and ram_data_into_mcu (input, 32): RAM handshake and read data.
REQ-008 SHALL have ports cs, we, oe (output, 1 each), address (output, 32), ram_data_in (output, 32) and data_size (output, 2): the single shared RAM port.
REQ-009 SHALL have port timeout_err, output, 1 bit: one-cycle pulse qualifying an aborted access.

Function
REQ-010 SHALL implement the states IDLE, FETCH, DREAD and DWRITE.
REQ-011 In IDLE with no request pending, SHALL stay in IDLE.
REQ-012 In IDLE with only if_req high, SHALL go to FETCH.
REQ-013 In IDLE with only d_req high, SHALL go to DREAD if d_we=0, or DWRITE if d_we=1.
REQ-014 In IDLE with both requests high, SHALL grant data, unless starve_cnt equals STARVE_MAX, in which case SHALL grant fetch.
REQ-015 SHALL control starve_cnt (8 bits) as follows:
- increment on each data grant made while if_req is high;
- clear on each fetch grant;
- saturate at STARVE_MAX.
REQ-016 On the grant edge, SHALL do all of the following:
- register the requester's address, size and write data onto address, data_size and ram_data_in;
- pulse the matching gnt for exactly one cycle;
- clear the wait counter.
REQ-017 Address and size for a fetch SHALL be:
- address = {if_addr[31:2], 2'b00};
- data_size = 2'b10 (word).
REQ-018 Data size for a data access SHALL be d_size, with encoding 00 byte, 01 halfword, 10 word; the value 11 SHALL be driven as 10.
REQ-019 Port outputs by state SHALL be:
- FETCH/DREAD: cs=1, oe=1, we=0;
- DWRITE: cs=1, we=1, oe=0;
- IDLE: cs=we=oe=0.
REQ-020 address, data_size and ram_data_in SHALL hold stable from the grant edge until the state returns to IDLE.
REQ-021 In an access state, ram_ready=1 sampled at a rising edge SHALL cause all of the following:
- return to IDLE;
- pulse the matching done for one cycle;
- for reads, capture ram_data_into_mcu into if_rdata or d_rdata;
- leave the rdata of the other requester unchanged.
REQ-022 rdata registers SHALL hold their value until the next completed read of the same requester.
REQ-023 Minimum latency SHALL be: req high in IDLE at edge N -> gnt high after N; ram_ready high after N+1 -> done high after N+1, with rdata valid at the same time; the next grant is possible at edge N+2.
REQ-024 Each access-state cycle without ram_ready SHALL increment the wait counter.
REQ-025 If the wait counter reaches TIMEOUT with ram_ready low, SHALL do all of the following:
- return to IDLE;
- pulse done and timeout_err together;
- leave rdata unchanged.
REQ-026 Deasserting a request after its grant SHALL NOT abort the access; the access SHALL complete or time out normally.
REQ-027 A requester SHALL hold req high until its done; req still high in the done cycle SHALL be treated as a new request.
REQ-028 ram_ready while in IDLE SHALL be ignored.
REQ-029 if_gnt and d_gnt SHALL never be high in the same cycle; if_done and d_done SHALL never be high in the same cycle.

Reset
REQ-030 rst low SHALL immediately, without waiting for clk, force all of the following:
- state IDLE; starve_cnt and wait counter 0;
- cs=we=oe=0; address, ram_data_in, if_rdata and d_rdata all 0; data_size=00;
- all gnt, done and timeout_err 0.
REQ-031 Reset during an access SHALL abandon that access with no done pulse; the first grant after rst rises SHALL follow the IDLE rules.

Verification
REQ-032 Fetch test: if_req, if_addr=0x00000103, ram_ready after 1 cycle with data 0xE3A01005 -> address=0x00000100, data_size=10, oe=1, if_done one cycle later with if_rdata=0xE3A01005.
REQ-033 Write test: d_req, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_size=00, ram_ready after 3 cycles -> we=1, cs=1, ram_data_in=0xDEADBEEF, data_size=00 for 4 cycles, then d_done pulses.
REQ-034 Starvation test: both requests held high, zero-wait RAM -> grant order D,D,D,D,F,D,D,D,D,F.
REQ-035 Timeout test: d_req read with ram_ready held low, TIMEOUT=15 -> d_done and timeout_err pulse together 15 cycles after the grant; d_rdata unchanged.
REQ-036 Reset test: rst low two cycles into a DREAD -> cs, oe and address become 0 asynchronously and no done pulse occurs; after release, a new if_req is granted normally.
